// File: rtl/mem_resp_replay_buffer_if.sv
// Handshake bundle between the data-cache response side, the replay buffer
// and the pending memory request queue's replay port.
interface mem_resp_replay_buffer_if #(
   parameter int RESP_BUF_ENTRIES = 4,
   parameter int TAG_WIDTH        = 6,
   parameter int DATA_WIDTH       = 64
);
   localparam int CW = $clog2(RESP_BUF_ENTRIES) + 1;

   logic                  resp_valid_i;
   logic                  resp_ready_o;
   logic [TAG_WIDTH-1:0]  resp_tag_i;
   logic [DATA_WIDTH-1:0] resp_data_i;
   logic [2:0]            resp_size_i;
   logic [2:0]            resp_offset_i;
   logic                  flush_i;
   logic                  replay_ready_i;
   logic                  replay_valid_o;
   logic [TAG_WIDTH-1:0]  replay_tag_o;
   logic [DATA_WIDTH-1:0] replay_data_o;
   logic [CW-1:0]         count_o;
   logic                  overflow_o;

   modport slave (
      input  resp_valid_i, resp_tag_i, resp_data_i, resp_size_i, resp_offset_i,
      input  flush_i, replay_ready_i,
      output resp_ready_o, replay_valid_o, replay_tag_o, replay_data_o,
      output count_o, overflow_o
   );

   modport master (
      output resp_valid_i, resp_tag_i, resp_data_i, resp_size_i, resp_offset_i,
      output flush_i, replay_ready_i,
      input  resp_ready_o, replay_valid_o, replay_tag_o, replay_data_o,
      input  count_o, overflow_o
   );
endinterface

// File: rtl/mem_resp_replay_buffer.sv
// FIFO of out-of-order load responses, aligned and extended into one replay per cycle.
// Optional same-cycle forwarding into an empty buffer: define MEM_RESP_BYPASS_EN.
module mem_resp_replay_buffer #(
   parameter int RESP_BUF_ENTRIES = 4,
   parameter int TAG_WIDTH        = 6,
   parameter int DATA_WIDTH       = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   mem_resp_replay_buffer_if.slave bus
);
   localparam int PW = $clog2(RESP_BUF_ENTRIES);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(RESP_BUF_ENTRIES);

   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;

   logic [TAG_WIDTH-1:0]  r_tag_mem  [RESP_BUF_ENTRIES];
   logic [DATA_WIDTH-1:0] r_data_mem [RESP_BUF_ENTRIES];
   logic [2:0]            r_size_mem [RESP_BUF_ENTRIES];
   logic [2:0]            r_off_mem  [RESP_BUF_ENTRIES];

   logic                  w_ready;
   logic                  w_fifo_valid;
   logic                  w_bypass;
   logic                  w_consume;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;
   logic [TAG_WIDTH-1:0]  w_src_tag;
   logic [DATA_WIDTH-1:0] w_src_data;
   logic [2:0]            w_src_size;
   logic [2:0]            w_src_off;
   logic [2:0]            w_off_al;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_ext;
   logic                  w_sgn;

   // Ready depends only on registered state plus flush/reset, never on replay_ready_i.
   assign w_ready      = ~rst_i & ~bus.flush_i & (r_count < FULL);
   assign w_fifo_valid = (r_count != '0) & ~bus.flush_i;

`ifdef MEM_RESP_BYPASS_EN
   assign w_bypass = (r_count == '0) & bus.resp_valid_i & ~bus.flush_i & ~rst_i;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_consume = w_bypass & bus.replay_ready_i;
   assign w_push    = bus.resp_valid_i & w_ready & ~w_consume;
   assign w_pop     = w_fifo_valid & bus.replay_ready_i;
   assign w_valid   = w_fifo_valid | w_bypass;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_tag_mem[r_tail]  <= bus.resp_tag_i;
         r_data_mem[r_tail] <= bus.resp_data_i;
         r_size_mem[r_tail] <= bus.resp_size_i;
         r_off_mem[r_tail]  <= bus.resp_offset_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (bus.resp_valid_i & ~w_ready & ~bus.flush_i)
            r_overflow <= 1'b1;
         if (bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push)
               r_tail <= r_tail + 1'b1;
            if (w_pop)
               r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_comb begin
      w_src_tag  = r_tag_mem[r_head];
      w_src_data = r_data_mem[r_head];
      w_src_size = r_size_mem[r_head];
      w_src_off  = r_off_mem[r_head];
      if (w_bypass) begin
         w_src_tag  = bus.resp_tag_i;
         w_src_data = bus.resp_data_i;
         w_src_size = bus.resp_size_i;
         w_src_off  = bus.resp_offset_i;
      end
   end

   // Sub-doubleword loads drop the low offset bits that cannot be naturally aligned.
   always_comb begin
      w_off_al = 3'd0;
      case (w_src_size[1:0])
         2'd0:    w_off_al = w_src_off;
         2'd1:    w_off_al = {w_src_off[2:1], 1'b0};
         2'd2:    w_off_al = {w_src_off[2], 2'b00};
         default: w_off_al = 3'd0;
      endcase
   end

   assign w_shifted = w_src_data >> {w_off_al, 3'b000};

   always_comb begin
      w_ext = w_src_data;
      w_sgn = 1'b0;
      case (w_src_size[1:0])
         2'd0: begin
            w_sgn = ~w_src_size[2] & w_shifted[7];
            w_ext = {{(DATA_WIDTH-8){w_sgn}}, w_shifted[7:0]};
         end
         2'd1: begin
            w_sgn = ~w_src_size[2] & w_shifted[15];
            w_ext = {{(DATA_WIDTH-16){w_sgn}}, w_shifted[15:0]};
         end
         2'd2: begin
            w_sgn = ~w_src_size[2] & w_shifted[31];
            w_ext = {{(DATA_WIDTH-32){w_sgn}}, w_shifted[31:0]};
         end
         default: begin
            w_sgn = 1'b0;
            w_ext = w_src_data;
         end
      endcase
   end

   assign bus.resp_ready_o   = w_ready;
   assign bus.replay_valid_o = w_valid;
   assign bus.replay_tag_o   = w_valid ? w_src_tag : '0;
   assign bus.replay_data_o  = w_valid ? w_ext : '0;
   assign bus.count_o        = r_count;
   assign bus.overflow_o     = r_overflow;

endmodule

// File: doc/mem_resp_replay_buffer.md
Name: mem_resp_replay_buffer

Overview:
- Sits directly upstream of the pending memory request queue.
- Accepts load responses from the data-cache interface, which may arrive in any order and are identified by tag, and buffers them in a small FIFO.
- Aligns and sign/zero-extends the load data, then presents one replay per cycle (valid, tag, data) to the pending memory request queue's replay port.
- Provides backpressure to the cache side and flushes together with the pipeline.

Parameters:
- RESP_BUF_ENTRIES, 4, FIFO depth; power of two, at least 2.
- TAG_WIDTH, 6, width of the instruction tag; matches reg_t.
- DATA_WIDTH, 64, response data width; fixed at 64 (bus64_t).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- resp_valid_i  in  1  cache response valid.
- resp_ready_o  out  1  buffer can accept a response this cycle.
- resp_tag_i  in  TAG_WIDTH  tag of the responding load.
- resp_data_i  in  64  raw 64-bit aligned doubleword from the cache.
- resp_size_i  in  3  [1:0] = 0 B, 1 H, 2 W, 3 D; [2] = 1 unsigned.
- resp_offset_i  in  3  byte offset within the doubleword (addr[2:0]).
- flush_i  in  1  pipeline flush.
- replay_ready_i  in  1  downstream can take a replay.
- replay_valid_o  out  1  replay available; drives replay_valid_i of the queue.
- replay_tag_o  out  TAG_WIDTH  drives tag_next_i.
- replay_data_o  out  64  extracted and extended data; drives replay_data_i.
- count_o  out  $clog2(RESP_BUF_ENTRIES)+1  occupied entries.
- overflow_o  out  1  sticky error flag: a response was presented while not ready.

Behaviour:
- Reset (rst_i = 1, asynchronous): head = tail = count = 0, overflow_o = 0.
  - Outputs during reset: replay_valid_o = 0, resp_ready_o = 0.
  - replay_tag_o and replay_data_o read 0 whenever replay_valid_o = 0.
  - Entry storage is not reset.
- Ready: resp_ready_o = ~rst_i & ~flush_i & (count < RESP_BUF_ENTRIES). It is registered-state only; there is no combinational path from replay_ready_i.
- Push:
  - Condition: push = resp_valid_i & resp_ready_o.
  - Stores {tag, data, size, offset} at tail; tail += 1, modulo RESP_BUF_ENTRIES (natural wrap).
- Pop:
  - Condition: pop = replay_valid_o & replay_ready_i. On pop, head += 1 with wrap.
  - replay_valid_o = (count > 0) & ~flush_i.
  - Outputs hold stable while replay_valid_o = 1 and replay_ready_i = 0.
- Count: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
  - A full buffer does not accept a push even if it pops in the same cycle; ready stays 0 for that cycle.
- Latency: a response accepted in cycle N is visible on replay_valid_o no earlier than cycle N+1. Ordering is strictly FIFO.
- Data extraction (combinational on the head entry), with sh = offset*8:
  - B: take data[sh+7:sh]; sign-extend from bit 7 unless size[2] = 1.
  - H: take data[sh+15:sh]; offset[0] is ignored (taken as 0).
  - W: take data[sh+31:sh]; offset[1:0] is ignored.
  - D: pass data unchanged; offset and size[2] are ignored.
- Flush (synchronous, priority over push and pop): the next state is head = tail = count = 0.
  - A response presented in the flush cycle is dropped.
  - replay_valid_o = 0 in the flush cycle.
  - overflow_o is not cleared by flush.
- Overflow: resp_valid_i & ~resp_ready_o & ~flush_i & ~rst_i sets overflow_o; it clears only on reset. The dropped response is not stored.
- Reset asserted mid-operation: all state clears immediately, regardless of the clock.

Optional Feature:
- Macro: MEM_RESP_BYPASS_EN.
- Defined:
  - When count = 0 and resp_valid_i = 1 (no flush), the response is forwarded combinationally, so replay_valid_o = 1 in the same cycle with the extracted data.
  - If replay_ready_i = 1, the response is consumed without being written and the pointers do not move. Otherwise it is pushed normally.
  - resp_ready_o is unchanged.
- Not defined: minimum latency is 1 cycle and there is no combinational path from resp_* to replay_*.

Test Plan:
- Byte load, sign-extended: push tag = 5, data = 64'h0000_0000_0080_0000, size = 0 (B signed), offset = 2, replay_ready_i = 1. Next cycle: replay_valid_o = 1, tag = 5, data = 64'hFFFF_FFFF_FFFF_FF80. Then count returns to 0.
- Half and word loads: unsigned halfword, offset = 6, data = 64'hBEEF_0000_0000_0000 → 64'h0000_0000_0000_BEEF. Signed word, offset = 4, data = 64'h8000_0001_xxxx_xxxx → 64'hFFFF_FFFF_8000_0001.
- Fill and order: replay_ready_i = 0; push tags 1, 2, 3, 4. Expect count_o = 4 and resp_ready_o = 0. Push tag 9 → overflow_o = 1 and tag 9 is absent. Then set replay_ready_i = 1: replays come out as 1, 2, 3, 4 on consecutive cycles.
- Wrap with concurrent push and pop: keep count at 2 while pushing and popping every cycle for 10 cycles. Expect count stable at 2, tags in order, correct output after pointer wrap.
- Flush: with 3 entries buffered, assert flush_i together with resp_valid_i (tag = 7). Next cycle: count_o = 0 and replay_valid_o = 0; tag 7 never replays.
- Async reset mid-stream: assert rst_i between clock edges with 2 entries buffered. Immediately count_o = 0, replay_valid_o = 0, overflow_o = 0. With the bypass macro defined, a response into an empty buffer replays in the same cycle.
